audio_proc_transceiver: RTL and testbench
=========================================

// Module: audio_proc_transceiver
// PURPOSE
//  SPI-style audio receiver plus 1-bit PDM DAC driver for a 12.288 MHz FPGA audio path.
//  - Generates the serial bit clock for the upstream ADC.
//  - Deserialises 16-bit signed PCM words (MSB first) framed by an active-low chip select.
//  - Converts each word to offset binary and drives a first-order sigma-delta PDM output.
//  - Reports status on three LEDs.
// PARAMETERS
//  CLK_DIV  4   input_clk cycles per serial_clk period; even, >=2 (12.288 MHz -> 3.072 MHz)
//  DATA_W   16  PCM word width, two's complement
// PORTS
//  input_clk    in   1       system clock, 12.288 MHz; the only clock
//  reset_n      in   1       asynchronous, active-HIGH reset (1 = in reset); name kept per codebase
//  spi_mosi     in   1       serial PCM data from ADC; changes on serial_clk falling edge
//  spi_cs       in   1       active-low frame select from ADC
//  serial_clk   out  1       generated bit clock, registered, 50% duty
//  dac_pdm_out  out  1       registered PDM bitstream, one bit per input_clk cycle
//  RED_LED      out  1       1 while reset asserted
//  GREEN_LED    out  1       toggles on every completed word
//  BLUE_LED     out  1       MSB (sign) of last completed word
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0 except RED_LED=1.
//   - div counter=0, bit counter=0, shift reg=0, PDM accumulator=0.
//   - sample register = 0x8000 offset (mid-scale silence).
//  Clock gen:
//   - div counter runs 0..CLK_DIV-1.
//   - serial_clk=1 for counts >= CLK_DIV/2, else 0; it is registered.
//   - rise_evt = input_clk edge on which serial_clk goes 0->1.
//  Capture (on rise_evt only; inputs are launched half a bit period earlier, so no synchroniser):
//   - spi_cs=1: bit counter cleared, partial word discarded.
//   - spi_cs=0: shift <= {shift[14:0], spi_mosi}; bit counter++.
//   - On the 16th bit, on that same edge:
//       - sample register <= {~bit15, bits14..0} (two's complement -> offset binary).
//       - GREEN_LED toggles; BLUE_LED <= bit15.
//       - bit counter wraps to 0.
//   - If CS stays low beyond 16 bits, the next 16 bits form the next word.
//  PDM (every input_clk cycle):
//   - acc[16:0] <= {1'b0, acc[15:0]} + {1'b0, sample}; dac_pdm_out <= carry (acc[16] of the new sum).
//   - A new sample takes effect from the cycle after it is latched; the accumulator is not cleared on update.
//   - Ones density = sample/65536 (0x0000 offset -> all 0; 0xFFFF -> all 1 except 1 of 65536).
//  Edge cases:
//   - CS rising mid-word: no update, LEDs unchanged.
//   - Reset mid-word: word lost, output returns to silence after release.
// TESTING
//  1. Reset held 200 ns, then released:
//     - serial_clk period 4 input_clk cycles.
//     - PDM alternates 0/1 (mid-scale); RED_LED=0.
//  2. Send 0x0000:
//     - PDM exactly 50% ones over any 2^n window, n>=1.
//     - GREEN_LED toggles; BLUE_LED=0.
//  3. Send 0x7FFF:
//     - PDM all 1s except 1 zero per 65536 cycles (0 zeros in 5 us).
//     - BLUE_LED=0.
//  4. Send 0x8000:
//     - PDM constant 0 from the cycle after latch; BLUE_LED=1.
//  5. Send 0x4000:
//     - PDM 75% ones, pattern 1,1,1,0 repeating after settling.
//  6. Raise CS after 8 bits of 0x8000:
//     - sample unchanged; GREEN_LED unchanged.
//     - A following full word is received correctly.

Source files
------------

// File: rtl/audio_proc_transceiver_if.sv
// audio_proc_transceiver_if: ADC link (spi_mosi, spi_cs in; serial_clk out), dac_pdm_out and RED/GREEN/BLUE status LEDs
interface audio_proc_transceiver_if;
  logic spi_mosi;
  logic spi_cs;
  logic serial_clk;
  logic dac_pdm_out;
  logic RED_LED;
  logic GREEN_LED;
  logic BLUE_LED;
  modport master(output spi_mosi, spi_cs, input serial_clk, dac_pdm_out, RED_LED, GREEN_LED, BLUE_LED);
  modport slave(input spi_mosi, spi_cs, output serial_clk, dac_pdm_out, RED_LED, GREEN_LED, BLUE_LED);
endinterface

// File: rtl/audio_proc_transceiver.sv
// audio_proc_transceiver: bit clock gen + PCM deserialiser + sigma-delta PDM DAC; ports input_clk, reset_n (active-high async), bus (slave: spi_mosi/spi_cs in, serial_clk/dac_pdm_out/LEDs out)
module audio_proc_transceiver #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input logic input_clk,
  input logic reset_n,
  audio_proc_transceiver_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);
  logic [CW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] shift, sample, word;
  logic [DATA_W:0] acc, sum;
  logic rise_evt, last_bit;
  always_comb begin
    div_nxt  = (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);
    rise_evt = div_nxt == CW'(CLK_DIV / 2);
    last_bit = bit_cnt == BW'(DATA_W - 1);
    word     = {shift[DATA_W-2:0], bus.spi_mosi};
    sum      = {1'b0, acc[DATA_W-1:0]} + {1'b0, sample};
  end
  always_ff @(posedge input_clk or posedge reset_n)
    if (reset_n) begin
      div_cnt         <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      sample          <= {1'b1, {(DATA_W-1){1'b0}}};
      acc             <= '0;
      bus.serial_clk  <= 1'b0;
      bus.dac_pdm_out <= 1'b0;
      bus.RED_LED     <= 1'b1;
      bus.GREEN_LED   <= 1'b0;
      bus.BLUE_LED    <= 1'b0;
    end else begin
      div_cnt         <= div_nxt;
      bus.serial_clk  <= div_nxt >= CW'(CLK_DIV / 2);
      acc             <= sum;
      bus.dac_pdm_out <= sum[DATA_W];
      bus.RED_LED     <= 1'b0;
      if (rise_evt) begin
        if (bus.spi_cs) bit_cnt <= '0;
        else begin
          shift   <= word;
          bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
          if (last_bit) begin
            sample        <= {~word[DATA_W-1], word[DATA_W-2:0]};
            bus.GREEN_LED <= ~bus.GREEN_LED;
            bus.BLUE_LED  <= word[DATA_W-1];
          end
        end
      end
    end
endmodule

// File: tb/tb_audio_proc_transceiver.sv
// tb_audio_proc_transceiver: directed words with scoreboarded LED and PDM density checks
module tb_audio_proc_transceiver;
  logic input_clk = 1'b0;
  logic reset_n = 1'b1;
  audio_proc_transceiver_if ifc();
  audio_proc_transceiver #(.CLK_DIV(4), .DATA_W(16)) dut (.input_clk(input_clk), .reset_n(reset_n), .bus(ifc));
  always #40 input_clk = ~input_clk;
  typedef struct {
    logic blue;
    int   win;
    int   ones;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic count_ones(input int win, output int ones);
    ones = 0;
    repeat (win) begin
      @(negedge input_clk);
      ones += int'(ifc.dac_pdm_out);
    end
  endtask
  task automatic sclk_period(output int p);
    int last;
    logic prev;
    last = -1;
    p = 0;
    prev = ifc.serial_clk;
    for (int i = 0; i < 20 && p == 0; i++) begin
      @(negedge input_clk);
      if (ifc.serial_clk && !prev) begin
        if (last >= 0) p = i - last;
        last = i;
      end
      prev = ifc.serial_clk;
    end
  endtask
  task automatic send(input logic [15:0] w, input int n);
    @(negedge ifc.serial_clk); #1;
    ifc.spi_cs = 1'b0;
    ifc.spi_mosi = w[15];
    for (int i = 14; i >= 16 - n; i--) begin
      @(negedge ifc.serial_clk); #1;
      ifc.spi_mosi = w[i];
    end
    @(negedge ifc.serial_clk); #1;
    ifc.spi_cs = 1'b1;
  endtask
  task automatic send_word(input logic [15:0] w, input logic blue, input int win, input int ones);
    exp_t e;
    e.blue = blue;
    e.win = win;
    e.ones = ones;
    sb.push_back(e);
    send(w, 16);
  endtask
  initial begin
    logic prev_g;
    exp_t e;
    int ones;
    prev_g = 1'b0;
    forever begin
      @(negedge input_clk);
      if (reset_n) prev_g = ifc.GREEN_LED;
      else if (ifc.GREEN_LED !== prev_g) begin
        prev_g = ifc.GREEN_LED;
        if (sb.size() == 0) check("unexpected_word", 32'(ifc.GREEN_LED), 32'(~ifc.GREEN_LED));
        else begin
          e = sb.pop_front();
          check("word_blue", 32'(ifc.BLUE_LED), 32'(e.blue));
          repeat (4) @(negedge input_clk);
          count_ones(e.win, ones);
          check("word_pdm_ones", ones, e.ones);
        end
      end
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int p, ones, alt, t;
    logic prev_p, g;
    ifc.spi_cs = 1'b1;
    ifc.spi_mosi = 1'b0;
    repeat (2) @(negedge input_clk);
    check("rst_red", 32'(ifc.RED_LED), 1);
    check("rst_sclk", 32'(ifc.serial_clk), 0);
    check("rst_pdm", 32'(ifc.dac_pdm_out), 0);
    check("rst_green", 32'(ifc.GREEN_LED), 0);
    check("rst_blue", 32'(ifc.BLUE_LED), 0);
    @(negedge input_clk);
    reset_n = 1'b0;
    @(negedge input_clk);
    check("run_red", 32'(ifc.RED_LED), 0);
    sclk_period(p);
    check("sclk_period", p, 4);
    alt = 0;
    @(negedge input_clk);
    prev_p = ifc.dac_pdm_out;
    repeat (8) begin
      @(negedge input_clk);
      if (ifc.dac_pdm_out !== prev_p) alt++;
      prev_p = ifc.dac_pdm_out;
    end
    check("midscale_alternate", alt, 8);
    count_ones(16, ones);
    check("midscale_ones", ones, 8);
    send_word(16'h0000, 1'b0, 16, 8);
    repeat (30) @(negedge input_clk);
    send_word(16'h7FFF, 1'b0, 64, 64);
    repeat (80) @(negedge input_clk);
    send_word(16'h8000, 1'b1, 16, 0);
    repeat (30) @(negedge input_clk);
    send_word(16'h4000, 1'b0, 16, 12);
    repeat (30) @(negedge input_clk);
    g = ifc.GREEN_LED;
    send(16'h8000, 8);
    repeat (8) @(negedge input_clk);
    check("abort_green", 32'(ifc.GREEN_LED), 32'(g));
    count_ones(16, ones);
    check("abort_pdm_ones", ones, 12);
    send_word(16'h8000, 1'b1, 16, 0);
    repeat (30) @(negedge input_clk);
    @(negedge ifc.serial_clk); #1;
    ifc.spi_cs = 1'b0;
    ifc.spi_mosi = 1'b1;
    repeat (3) @(negedge ifc.serial_clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(negedge input_clk);
    check("midrst_red", 32'(ifc.RED_LED), 1);
    reset_n = 1'b0;
    ifc.spi_cs = 1'b1;
    repeat (2) @(negedge input_clk);
    check("midrst_green", 32'(ifc.GREEN_LED), 0);
    check("midrst_blue", 32'(ifc.BLUE_LED), 0);
    count_ones(16, ones);
    check("midrst_pdm_ones", ones, 8);
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge input_clk);
      t++;
    end
    check("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
